apb_master_mux: RTL and testbench

- Parametrised next-generation APB requester, generalising the single-slave APB master.
- Accepts one command at a time on a valid/ready system interface and decodes the upper address bits to one of NUM_SLV slave selects.
- Runs the APB SETUP/ACCESS sequence, muxes back the selected slave's rdata/ready/slverr, and returns a coded response (OK, slave error, timeout, decode error).
- Sits between system tasks and a bank of APB slaves.

---
 rtl/apb_master_mux.sv | 208 ++++++++++++++++++++
 tb/tb_apb_master_mux.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_mux.sv
// apb_master_mux: APB requester with a valid/ready command port and an
// address decoder driving NUM_SLV one-hot slave selects. Each command runs
// the APB SETUP/ACCESS sequence and returns a coded response
// (00 OK, 01 SLVERR, 10 timeout, 11 decode error).
// Optional feature: define APB_TIMEOUT_EN to abort an ACCESS phase after
// TIMEOUT consecutive cycles with ready low; without it ACCESS waits forever.
module apb_master_mux #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int NUM_SLV = 4,
  parameter int SLV_AW  = 5,
  parameter int TIMEOUT = 20,
  parameter int TO_W    = 8
) (
  input  logic                      apb_clk,
  input  logic                      apb_reset,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [ADDR_W-1:0]         cmd_addr,
  input  logic                      cmd_write,
  input  logic [DATA_W-1:0]         cmd_wdata,
  output logic                      rsp_valid,
  output logic [1:0]                rsp_err,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic [ADDR_W-1:0]         apb_addr,
  output logic                      apb_write,
  output logic [DATA_W-1:0]         apb_wdata,
  output logic [NUM_SLV-1:0]        apb_selx,
  output logic                      apb_en,
  input  logic [NUM_SLV*DATA_W-1:0] apb_rdata,
  input  logic [NUM_SLV-1:0]        apb_ready,
  input  logic [NUM_SLV-1:0]        apb_slverr
);

  localparam int IDX_W = ADDR_W - SLV_AW;

  localparam logic [1:0] RSP_OK      = 2'b00;
  localparam logic [1:0] RSP_SLVERR  = 2'b01;
  localparam logic [1:0] RSP_TIMEOUT = 2'b10;
  localparam logic [1:0] RSP_DECERR  = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_e;

  state_e              state_q, state_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [1:0]          rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                write_q, write_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [NUM_SLV-1:0]  selx_q, selx_d;
  logic                en_q, en_d;
`ifdef APB_TIMEOUT_EN
  logic [TO_W-1:0]     cnt_q, cnt_d;
`endif

  logic [IDX_W-1:0]    cmd_idx;
  logic [NUM_SLV-1:0]  dec_oh;
  logic                ready_mux;
  logic                slverr_mux;
  logic [DATA_W-1:0]   rdata_mux;

  assign cmd_idx = cmd_addr[ADDR_W-1:SLV_AW];

  // Decode the command's region index into a one-hot select; all zero means
  // the address falls outside the populated slaves.
  always_comb begin
    dec_oh = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (cmd_idx == IDX_W'(i)) dec_oh[i] = 1'b1;
    end
  end

  // Return-path mux: the registered select gates out every other slave.
  always_comb begin
    ready_mux  = |(apb_ready & selx_q);
    slverr_mux = |(apb_slverr & selx_q);
    rdata_mux  = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      rdata_mux = rdata_mux | (apb_rdata[i*DATA_W +: DATA_W] & {DATA_W{selx_q[i]}});
    end
  end

  // Next-state logic; every output register's next value is computed here
  // so all outputs come straight from flops.
  always_comb begin
    // NOTE: every target gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    cmd_ready_d = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    addr_d      = addr_q;
    write_d     = write_q;
    wdata_d     = wdata_q;
    selx_d      = selx_q;
    en_d        = en_q;
`ifdef APB_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        cmd_ready_d = 1'b1;
        if (cmd_valid && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          addr_d      = cmd_addr;
          write_d     = cmd_write;
          wdata_d     = cmd_write ? cmd_wdata : '0;
          if (|dec_oh) begin
            state_d = S_SETUP;
            selx_d  = dec_oh;
`ifdef APB_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end else begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = RSP_DECERR;
            rsp_rdata_d = '0;
          end
        end
      end
      S_SETUP: begin
        state_d = S_ACCESS;
        en_d    = 1'b1;
      end
      S_ACCESS: begin
        if (ready_mux) begin
          state_d     = S_RESP;
          selx_d      = '0;
          en_d        = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = slverr_mux ? RSP_SLVERR : RSP_OK;
          rsp_rdata_d = (!write_q && !slverr_mux) ? rdata_mux : '0;
        end
`ifdef APB_TIMEOUT_EN
        else if (cnt_q == TO_W'(TIMEOUT - 1)) begin
          state_d     = S_RESP;
          selx_d      = '0;
          en_d        = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = RSP_TIMEOUT;
          rsp_rdata_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      S_RESP: begin
        state_d     = S_IDLE;
        cmd_ready_d = 1'b1;
      end
      default: begin
        state_d     = S_IDLE;
        cmd_ready_d = 1'b1;
        selx_d      = '0;
        en_d        = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge apb_clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (apb_reset) begin
      state_q     <= S_IDLE;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= RSP_OK;
      rsp_rdata_q <= '0;
      addr_q      <= '0;
      write_q     <= 1'b0;
      wdata_q     <= '0;
      selx_q      <= '0;
      en_q        <= 1'b0;
`ifdef APB_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      addr_q      <= addr_d;
      write_q     <= write_d;
      wdata_q     <= wdata_d;
      selx_q      <= selx_d;
      en_q        <= en_d;
`ifdef APB_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign apb_addr  = addr_q;
  assign apb_write = write_q;
  assign apb_wdata = wdata_q;
  assign apb_selx  = selx_q;
  assign apb_en    = en_q;

endmodule

// File: tb/tb_apb_master_mux.sv
// Testbench for apb_master_mux: a driver issues commands and pushes the
// expected response into a scoreboard queue; a slave-bank model answers
// APB transfers; a monitor pops and compares on every negedge.
module tb_apb_master_mux;

  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 32;
  localparam int NUM_SLV = 4;
  localparam int SLV_AW  = 5;
  localparam int TIMEOUT = 20;
  localparam int TO_W    = 8;
`ifdef APB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic                      clk = 1'b0;
  logic                      apb_reset;
  logic                      cmd_valid;
  logic                      cmd_ready;
  logic [ADDR_W-1:0]         cmd_addr;
  logic                      cmd_write;
  logic [DATA_W-1:0]         cmd_wdata;
  logic                      rsp_valid;
  logic [1:0]                rsp_err;
  logic [DATA_W-1:0]         rsp_rdata;
  logic [ADDR_W-1:0]         apb_addr;
  logic                      apb_write;
  logic [DATA_W-1:0]         apb_wdata;
  logic [NUM_SLV-1:0]        apb_selx;
  logic                      apb_en;
  logic [NUM_SLV*DATA_W-1:0] apb_rdata;
  logic [NUM_SLV-1:0]        apb_ready;
  logic [NUM_SLV-1:0]        apb_slverr;

  apb_master_mux #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_SLV(NUM_SLV),
    .SLV_AW(SLV_AW), .TIMEOUT(TIMEOUT), .TO_W(TO_W)
  ) dut (
    .apb_clk(clk), .apb_reset(apb_reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_write(cmd_write), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .apb_addr(apb_addr), .apb_write(apb_write), .apb_wdata(apb_wdata),
    .apb_selx(apb_selx), .apb_en(apb_en),
    .apb_rdata(apb_rdata), .apb_ready(apb_ready), .apb_slverr(apb_slverr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic              wr;
    logic [DATA_W-1:0] wdata;
    int                idx;
    bit                dec;
    int                acc;     // cycle in which the command was presented
    int                resp_k;  // cycles from acceptance to rsp_valid
    logic [1:0]        err;
    logic [DATA_W-1:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  // Slave-bank configuration for the transaction in flight.
  int                cur_wait   = 0;
  bit                cur_slverr = 1'b0;
  logic [DATA_W-1:0] cur_rdata  = '0;

  logic [1:0]        last_err   = 2'b00;
  logic [DATA_W-1:0] last_rdata = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Slave bank: junk on every unselected slave and outside ACCESS; the
  // selected slave raises ready after cur_wait low ACCESS cycles.
  initial begin : slave_bank
    int acc_cnt = 0;
    apb_ready  = '0;
    apb_slverr = '0;
    apb_rdata  = '0;
    forever begin
      @(negedge clk);
      apb_ready  = NUM_SLV'($urandom);
      apb_slverr = NUM_SLV'($urandom);
      for (int i = 0; i < NUM_SLV; i++) apb_rdata[i*DATA_W +: DATA_W] = $urandom;
      if (apb_en && (apb_selx != '0)) begin
        for (int i = 0; i < NUM_SLV; i++) begin
          if (apb_selx[i]) begin
            apb_ready[i] = (acc_cnt == cur_wait);
            if (acc_cnt == cur_wait) begin
              apb_slverr[i] = cur_slverr;
              apb_rdata[i*DATA_W +: DATA_W] = cur_rdata;
            end
          end
        end
        acc_cnt++;
      end else begin
        acc_cnt = 0;
      end
    end
  end

  // A reset drops any outstanding expectation and clears the response regs.
  always @(posedge clk) begin
    if (apb_reset) begin
      exp_q.delete();
      last_err   = 2'b00;
      last_rdata = '0;
    end
  end

  // Monitor: compares bus activity and responses against the scoreboard head.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_t e;
        int   k;
        e = exp_q[0];
        k = cyc - e.acc;
        if (k >= 1) begin
          if (rsp_valid) begin
            check("rsp_latency", 32'(k), 32'(e.resp_k));
            check("rsp_err", 32'(rsp_err), 32'(e.err));
            check("rsp_rdata", rsp_rdata, e.rdata);
            check("resp_selx", 32'(apb_selx), 32'd0);
            check("resp_en", 32'(apb_en), 32'd0);
            last_err   = e.err;
            last_rdata = e.rdata;
            void'(exp_q.pop_front());
          end else if (k >= e.resp_k) begin
            check("rsp_valid_missing", 32'(rsp_valid), 32'd1);
            void'(exp_q.pop_front());
          end else begin
            check("selx", 32'(apb_selx), e.dec ? 32'd0 : 32'(1 << e.idx));
            check("en", 32'(apb_en), (k >= 2) ? 32'd1 : 32'd0);
            check("busy_cmd_ready", 32'(cmd_ready), 32'd0);
            check("hold_err", 32'(rsp_err), 32'(last_err));
            check("hold_rdata", rsp_rdata, last_rdata);
            if (k == 1) begin
              check("apb_addr", 32'(apb_addr), 32'(e.addr));
              check("apb_write", 32'(apb_write), 32'(e.wr));
              check("apb_wdata", apb_wdata, e.wdata);
            end
          end
        end
      end else if (!apb_reset) begin
        check("no_spurious_rsp", 32'(rsp_valid), 32'd0);
        check("idle_hold_err", 32'(rsp_err), 32'(last_err));
      end
    end
  end

  // Reference model: outcome follows from the address region, the slave's
  // wait count and error flag, and the timeout limit.
  task automatic issue(input logic [ADDR_W-1:0] addr, input bit wr,
                       input logic [DATA_W-1:0] wdata, input int wait_n,
                       input bit slverr, input logic [DATA_W-1:0] rdata);
    exp_t e;
    int   guard;
    bit   timed_out;
    int   n_acc;
    e.addr  = addr;
    e.wr    = wr;
    e.wdata = wr ? wdata : '0;
    e.idx   = int'(addr) / (1 << SLV_AW);
    e.dec   = (e.idx >= NUM_SLV);
    e.acc   = cyc;
    if (e.dec) begin
      e.resp_k = 1;
      e.err    = 2'b11;
      e.rdata  = '0;
    end else begin
      timed_out = TO_EN && (wait_n >= TIMEOUT);
      n_acc     = timed_out ? TIMEOUT : wait_n + 1;
      e.resp_k  = 2 + n_acc;
      e.err     = timed_out ? 2'b10 : (slverr ? 2'b01 : 2'b00);
      e.rdata   = (!wr && e.err == 2'b00) ? rdata : '0;
    end
    cur_wait   = wait_n;
    cur_slverr = slverr;
    cur_rdata  = rdata;
    cmd_valid  = 1'b1;
    cmd_addr   = addr;
    cmd_write  = wr;
    cmd_wdata  = wdata;
    exp_q.push_back(e);
    guard = 0;
    forever begin
      @(negedge clk);
      if (cmd_ready) break;
      // Busy: command inputs are scrambled to show they are not resampled.
      cmd_valid = 1'($urandom);
      cmd_addr  = ADDR_W'($urandom);
      cmd_write = 1'($urandom);
      cmd_wdata = $urandom;
      guard++;
      if (guard > 400) begin
        check("cmd_ready_return", 32'(cmd_ready), 32'd1);
        break;
      end
    end
    cmd_valid = 1'b0;
  endtask

  task automatic wait_ready();
    int guard = 0;
    while (!cmd_ready && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    check("wait_cmd_ready", 32'(cmd_ready), 32'd1);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    apb_reset = 1'b1;
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_write = 1'b0;
    cmd_wdata = '0;
    repeat (3) @(negedge clk);
    apb_reset = 1'b0;

    // Reset state
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_selx", 32'(apb_selx), 32'd0);
    check("rst_en", 32'(apb_en), 32'd0);
    check("rst_addr", 32'(apb_addr), 32'd0);
    check("rst_write", 32'(apb_write), 32'd0);
    check("rst_wdata", apb_wdata, 32'd0);

    // Directed cases
    issue(8'h04, 1'b1, 32'd10, 0, 1'b0, 32'hDEAD_BEEF);   // write slave 0
    issue(8'h25, 1'b0, 32'h55, 3, 1'b0, 32'h12);          // read slave 1, 3 waits
    issue(8'h40, 1'b1, 32'h77, 0, 1'b1, 32'hCAFE_0000);   // slave error
    issue(8'hA0, 1'b0, 32'h0,  0, 1'b0, 32'h1);           // decode error
    issue(8'h60, 1'b0, 32'h0,  100, 1'b0, 32'hABCD);      // slave 3 stalls
    issue(8'h3F, 1'b0, 32'h9,  1, 1'b1, 32'h5A5A);        // read with slverr

    // Reset in the middle of a wait-stated read
    wait_ready();
    cur_wait   = 10;
    cur_slverr = 1'b0;
    cur_rdata  = 32'h1234_5678;
    cmd_addr   = 8'h25;
    cmd_write  = 1'b0;
    cmd_wdata  = 32'h0;
    cmd_valid  = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_access_en", 32'(apb_en), 32'd1);
    apb_reset = 1'b1;
    @(negedge clk);
    apb_reset = 1'b0;
    check("post_rst_selx", 32'(apb_selx), 32'd0);
    check("post_rst_en", 32'(apb_en), 32'd0);
    check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    repeat (3) @(negedge clk);
    issue(8'h25, 1'b0, 32'h0, 2, 1'b0, 32'h0BAD_F00D);

    // Randomised traffic
    for (int t = 0; t < 40; t++) begin
      logic [ADDR_W-1:0] a;
      int                w;
      if ($urandom_range(0, 9) == 0)
        a = {3'($urandom_range(4, 7)), 5'($urandom)};
      else
        a = {3'($urandom_range(0, 3)), 5'($urandom)};
      w = ($urandom_range(0, 19) == 0) ? 25 : $urandom_range(0, 4);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue(a, 1'($urandom), $urandom, w, ($urandom_range(0, 3) == 0), $urandom);
    end

    repeat (4) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
